// File: rtl/uart_pkg.sv
// Shared UART constants and types.
//
// Contents:
//   BYTES_PER_WORD  number of received bytes packed into one word.
//   CLK_FREQ, BAUD  default system clock and line rate.
//   recv_state_t    state encoding for the receive-side word assembler.
package uart_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int CLK_FREQ       = 50_000_000;
    localparam int BAUD           = 115200;

    // IDLE: no partial word held; COLLECT: 1..3 bytes are waiting for the rest.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } recv_state_t;

endpackage

// File: rtl/sync_posedge_detect.sv
// Single-register rising-edge detector with synchronous active-high reset.
//
// Ports:
//   sys_clk  in   system clock
//   sys_rst  in   synchronous active-high reset
//   sig_in   in   level to watch (already in the sys_clk domain)
//   rise     out  high in every cycle where sig_in is high and was low
//                 in the previous cycle
module sync_posedge_detect (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic sig_in,
    output logic rise
);

    logic sig_d;

    // Remember last cycle's level. Clearing it on reset means a level that
    // is already high right after reset is reported as a fresh rise.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig_in;
        end
    end

    assign rise = sig_in & ~sig_d;

endmodule

// File: rtl/uart_recv_cache.sv
// Receive-side word assembler for the UART path.
//
// Packs every four received bytes into one 32-bit word, first byte in
// bits [31:24], and offers the word to the consumer through a one-word
// holding register with a valid/ready handshake. A partial word is
// dropped after TIMEOUT_CYCLES of silence between bytes.
//
// Ports:
//   sys_clk            in   system clock
//   sys_rst            in   synchronous active-high reset
//   recv_byte_data     in   [7:0]  byte from the UART receiver
//   recv_done          in   receiver done flag (level or pulse; one byte per rising edge)
//   recv_4bytes_data   out  [31:0] assembled word, stable while valid
//   recv_4bytes_valid  out  holding register is full
//   recv_4bytes_ready  in   consumer accepts the word
//   frame_timeout      out  one-cycle pulse: a partial word was discarded
//   overflow           out  one-cycle pulse: a completed word was dropped
//   bytes_pending      out  [1:0]  bytes held in the assembly register
module uart_recv_cache
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 13020,
    parameter int CNT_W          = 14
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  recv_byte_data,
    input  logic        recv_done,
    output logic [31:0] recv_4bytes_data,
    output logic        recv_4bytes_valid,
    input  logic        recv_4bytes_ready,
    output logic        frame_timeout,
    output logic        overflow,
    output logic [1:0]  bytes_pending
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       LAST_SLOT = 2'(BYTES_PER_WORD - 1);

    recv_state_t      state;
    logic [23:0]      assembly;
    logic [CNT_W-1:0] idle_cnt;
    logic             byte_rise;
    logic [31:0]      full_word;

    sync_posedge_detect u_done_edge (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .sig_in  (recv_done),
        .rise    (byte_rise)
    );

    // Only the low 24 bits of the assembly register are ever needed; the
    // fourth byte goes straight into the completed word.
    assign full_word = {assembly, recv_byte_data};

    // Assembly FSM, timeout counter and holding register in one block so
    // every output is registered. A byte arriving in the same cycle the
    // timeout expires is checked first and therefore wins. The handshake
    // clear is written before the state logic so that a word completing
    // on the accepting edge reloads the register in the same cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state             <= IDLE;
            assembly          <= 24'h0;
            idle_cnt          <= '0;
            bytes_pending     <= 2'd0;
            recv_4bytes_data  <= 32'h0;
            recv_4bytes_valid <= 1'b0;
            frame_timeout     <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            frame_timeout <= 1'b0;
            overflow      <= 1'b0;

            if (recv_4bytes_valid && recv_4bytes_ready) begin
                recv_4bytes_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (byte_rise) begin
                        assembly      <= {16'h0, recv_byte_data};
                        bytes_pending <= 2'd1;
                        idle_cnt      <= '0;
                        state         <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (byte_rise) begin
                        idle_cnt <= '0;
                        if (bytes_pending == LAST_SLOT) begin
                            assembly      <= 24'h0;
                            bytes_pending <= 2'd0;
                            state         <= IDLE;
                            if (!recv_4bytes_valid || recv_4bytes_ready) begin
                                recv_4bytes_data  <= full_word;
                                recv_4bytes_valid <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            assembly      <= {assembly[15:0], recv_byte_data};
                            bytes_pending <= bytes_pending + 2'd1;
                        end
                    end else if (idle_cnt == CNT_LAST) begin
                        assembly      <= 24'h0;
                        bytes_pending <= 2'd0;
                        idle_cnt      <= '0;
                        frame_timeout <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_recv_cache.sv
// Directed self-checking bench for uart_recv_cache with a short timeout.
module tb_uart_recv_cache;

    localparam int TIMEOUT_CYCLES = 20;
    localparam int CNT_W          = 5;

    logic        sys_clk;
    logic        sys_rst;
    logic [7:0]  recv_byte_data;
    logic        recv_done;
    logic [31:0] recv_4bytes_data;
    logic        recv_4bytes_valid;
    logic        recv_4bytes_ready;
    logic        frame_timeout;
    logic        overflow;
    logic [1:0]  bytes_pending;

    int checks   = 0;
    int failures = 0;

    int accept_count   = 0;
    int timeout_count  = 0;
    int overflow_count = 0;
    int base;

    uart_recv_cache #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .recv_byte_data    (recv_byte_data),
        .recv_done         (recv_done),
        .recv_4bytes_data  (recv_4bytes_data),
        .recv_4bytes_valid (recv_4bytes_valid),
        .recv_4bytes_ready (recv_4bytes_ready),
        .frame_timeout     (frame_timeout),
        .overflow          (overflow),
        .bytes_pending     (bytes_pending)
    );

    // 10 ns system clock.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Event counters sampled mid-cycle, away from the active edge.
    always @(negedge sys_clk) begin
        if (recv_4bytes_valid === 1'b1 && recv_4bytes_ready === 1'b1) accept_count++;
        if (frame_timeout === 1'b1) timeout_count++;
        if (overflow === 1'b1) overflow_count++;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one byte with recv_done held high for 'hold' cycles, then drop it.
    task automatic applyStimulus(input logic [7:0] b, input int hold);
        recv_byte_data = b;
        recv_done      = 1'b1;
        repeat (hold) step();
        recv_done      = 1'b0;
    endtask

    // Send four bytes MSB first, checking the pending count after each one.
    // Returns right after the last byte without an extra idle cycle.
    task automatic sendWord(input logic [31:0] w, input int hold, input int gap);
        logic [31:0] word_v;
        word_v = w;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(word_v[31 - 8*i -: 8], hold);
            checkOutput("bytes_pending_step", {30'h0, bytes_pending}, 32'((i + 1) % 4));
            if (i < 3) idle(gap);
        end
    endtask

    initial begin
        sys_rst           = 1'b1;
        recv_done         = 1'b0;
        recv_byte_data    = 8'h00;
        recv_4bytes_ready = 1'b1;
        idle(2);

        checkOutput("reset_data",     recv_4bytes_data, 32'h0);
        checkOutput("reset_valid",    {31'h0, recv_4bytes_valid}, 32'h0);
        checkOutput("reset_timeout",  {31'h0, frame_timeout}, 32'h0);
        checkOutput("reset_overflow", {31'h0, overflow}, 32'h0);
        checkOutput("reset_pending",  {30'h0, bytes_pending}, 32'h0);
        sys_rst = 1'b0;
        idle(2);

        // Single-cycle pulses, 10 cycles apart, consumer always ready.
        sendWord(32'h12345678, 1, 9);
        checkOutput("t1_valid", {31'h0, recv_4bytes_valid}, 32'h1);
        checkOutput("t1_data",  recv_4bytes_data, 32'h12345678);
        step();
        checkOutput("t1_valid_drop", {31'h0, recv_4bytes_valid}, 32'h0);

        // recv_done held for 5 cycles per byte: exactly one word.
        idle(2);
        base = accept_count;
        sendWord(32'hDEADBEEF, 5, 2);
        checkOutput("t2_valid_drop", {31'h0, recv_4bytes_valid}, 32'h0);
        checkOutput("t2_data",       recv_4bytes_data, 32'hDEADBEEF);
        idle(3);
        checkOutput("t2_pending",    {30'h0, bytes_pending}, 32'h0);
        checkOutput("t2_one_word",   32'(accept_count - base), 32'h1);

        // Backpressure: second word is dropped with one overflow pulse.
        recv_4bytes_ready = 1'b0;
        idle(2);
        base = overflow_count;
        sendWord(32'h01020304, 1, 2);
        checkOutput("t3_valid", {31'h0, recv_4bytes_valid}, 32'h1);
        checkOutput("t3_data",  recv_4bytes_data, 32'h01020304);
        idle(2);
        sendWord(32'hA0B0C0D0, 1, 2);
        checkOutput("t3_overflow_pulse", {31'h0, overflow}, 32'h1);
        checkOutput("t3_valid_held",     {31'h0, recv_4bytes_valid}, 32'h1);
        checkOutput("t3_data_held",      recv_4bytes_data, 32'h01020304);
        step();
        checkOutput("t3_overflow_end",   {31'h0, overflow}, 32'h0);
        recv_4bytes_ready = 1'b1;
        checkOutput("t3_data_accept",    recv_4bytes_data, 32'h01020304);
        step();
        checkOutput("t3_valid_drop",     {31'h0, recv_4bytes_valid}, 32'h0);
        checkOutput("t3_overflow_count", 32'(overflow_count - base), 32'h1);

        // Two bytes then silence: partial word discarded after the timeout.
        idle(2);
        base = timeout_count;
        applyStimulus(8'h11, 1);
        idle(2);
        applyStimulus(8'h22, 1);
        checkOutput("t4_pending2", {30'h0, bytes_pending}, 32'h2);
        idle(TIMEOUT_CYCLES - 1);
        checkOutput("t4_no_timeout_yet", {31'h0, frame_timeout}, 32'h0);
        checkOutput("t4_pending_held",   {30'h0, bytes_pending}, 32'h2);
        step();
        checkOutput("t4_timeout_pulse",  {31'h0, frame_timeout}, 32'h1);
        checkOutput("t4_pending_clear",  {30'h0, bytes_pending}, 32'h0);
        step();
        checkOutput("t4_timeout_end",    {31'h0, frame_timeout}, 32'h0);
        idle(4);
        checkOutput("t4_timeout_count",  32'(timeout_count - base), 32'h1);
        sendWord(32'h33445566, 1, 2);
        checkOutput("t4_valid", {31'h0, recv_4bytes_valid}, 32'h1);
        checkOutput("t4_data",  recv_4bytes_data, 32'h33445566);
        step();

        // A byte landing on the expiry cycle is kept and suppresses the timeout.
        applyStimulus(8'h77, 1);
        idle(TIMEOUT_CYCLES - 1);
        applyStimulus(8'h88, 1);
        checkOutput("t4b_pending",    {30'h0, bytes_pending}, 32'h2);
        checkOutput("t4b_no_timeout", {31'h0, frame_timeout}, 32'h0);
        idle(1);
        applyStimulus(8'h99, 1);
        idle(1);
        applyStimulus(8'hAA, 1);
        checkOutput("t4b_data",  recv_4bytes_data, 32'h778899AA);
        checkOutput("t4b_valid", {31'h0, recv_4bytes_valid}, 32'h1);
        step();
        checkOutput("t4b_timeout_count", 32'(timeout_count - base), 32'h1);

        // Accept and reload on the same edge.
        recv_4bytes_ready = 1'b0;
        idle(2);
        base = overflow_count;
        sendWord(32'hC1C2C3C4, 1, 1);
        checkOutput("t5_valid", {31'h0, recv_4bytes_valid}, 32'h1);
        idle(2);
        applyStimulus(8'hE1, 1);
        idle(1);
        applyStimulus(8'hE2, 1);
        idle(1);
        applyStimulus(8'hE3, 1);
        idle(1);
        recv_4bytes_ready = 1'b1;
        checkOutput("t5_old_data", recv_4bytes_data, 32'hC1C2C3C4);
        applyStimulus(8'hE4, 1);
        checkOutput("t5_valid_stays", {31'h0, recv_4bytes_valid}, 32'h1);
        checkOutput("t5_new_data",    recv_4bytes_data, 32'hE1E2E3E4);
        checkOutput("t5_no_overflow", {31'h0, overflow}, 32'h0);
        step();
        checkOutput("t5_valid_drop",  {31'h0, recv_4bytes_valid}, 32'h0);
        checkOutput("t5_overflow_count", 32'(overflow_count - base), 32'h0);

        // Reset in the middle of a word.
        idle(2);
        applyStimulus(8'hF1, 1);
        idle(1);
        applyStimulus(8'hF2, 1);
        idle(1);
        applyStimulus(8'hF3, 1);
        checkOutput("t6_pending3", {30'h0, bytes_pending}, 32'h3);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        checkOutput("t6_pending",  {30'h0, bytes_pending}, 32'h0);
        checkOutput("t6_valid",    {31'h0, recv_4bytes_valid}, 32'h0);
        checkOutput("t6_data",     recv_4bytes_data, 32'h0);
        checkOutput("t6_timeout",  {31'h0, frame_timeout}, 32'h0);
        checkOutput("t6_overflow", {31'h0, overflow}, 32'h0);
        base = timeout_count;
        sendWord(32'h0A0B0C0D, 1, 2);
        checkOutput("t6_word_valid", {31'h0, recv_4bytes_valid}, 32'h1);
        checkOutput("t6_word_data",  recv_4bytes_data, 32'h0A0B0C0D);
        step();
        idle(TIMEOUT_CYCLES + 5);
        checkOutput("t6_no_timeout", 32'(timeout_count - base), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_recv_cache.md
Name: uart_recv_cache

Overview:
- Receive-side counterpart of the UART send path.
- Collects bytes from the UART byte receiver and assembles each group of 4 bytes into one 32-bit word, MSB first: the first byte received becomes bits [31:24].
- Hands each completed word to the consumer (CNN input loader / command decoder) over a valid/ready handshake through a one-word holding register.
- Discards partial words after an inter-byte timeout.

Parameters:
- TIMEOUT_CYCLES, default 13020: sys_clk cycles of inter-byte silence after which a partial word is discarded. The default is 3 byte-times at 115200 baud on a 50 MHz clock. Must be ≥ 2.
- CNT_W, default 14: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- sys_clk  in  1  system clock; all logic is on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- recv_byte_data  in  8  byte from the UART receiver; valid whenever recv_done is high.
- recv_done  in  1  receiver done flag, a level or a pulse. Each rising edge is exactly one byte.
- recv_4bytes_data  out  32  assembled word; stable while recv_4bytes_valid is high.
- recv_4bytes_valid  out  1  holding register is full.
- recv_4bytes_ready  in  1  consumer accepts the word.
- frame_timeout  out  1  one-cycle pulse: a partial word was discarded.
- overflow  out  1  one-cycle pulse: a completed word was dropped.
- bytes_pending  out  2  number of bytes held in the assembly register (0..3).

Behaviour:
- Reset: when sys_rst is sampled high at a clock edge, all registers clear on that edge.
  - Outputs: recv_4bytes_data=0, recv_4bytes_valid=0, frame_timeout=0, overflow=0, bytes_pending=0.
  - Internal state: recv_done_d=0, timeout counter=0, FSM=IDLE.
  - Reset mid-word or mid-handshake discards everything without a timeout or overflow pulse.
- Edge detect:
  - rise = recv_done & ~recv_done_d, where recv_done_d is registered.
  - recv_done held high for N cycles counts as 1 byte.
  - recv_done high in the first cycle after reset counts as a rise.
- FSM has two states:
  - IDLE: bytes_pending=0. On rise: shift the byte in, go to COLLECT, bytes_pending=1, clear the counter.
  - COLLECT: on rise with bytes_pending<3: shift in, bytes_pending+1, clear the counter.
  - COLLECT, rise with bytes_pending=3: the word is complete, {assembly[23:0], recv_byte_data}. Go to IDLE with bytes_pending=0 and attempt the transfer below.
  - COLLECT, no rise: counter +1. When the counter reaches TIMEOUT_CYCLES-1, the next edge goes to IDLE, clears the assembly register, and pulses frame_timeout for one cycle.
  - A rise in the same cycle as the timeout expiry wins: the byte is taken, no timeout pulse.
  - The counter does not advance in IDLE.
- Transfer of a completed word:
  - Holding register empty, or recv_4bytes_valid & recv_4bytes_ready in the same cycle: load recv_4bytes_data and set recv_4bytes_valid=1 on that edge.
  - Latency: valid is high in the cycle after the cycle in which the 4th rise is sampled.
  - Holding register full and not being accepted: the new word is dropped, overflow pulses for one cycle, held data is unchanged.
- Handshake:
  - valid stays high until sampled with ready=1, then clears on that edge unless it is reloaded on the same edge.
  - ready is ignored while valid=0.
  - Data is stable while valid=1.
- Byte assembly continues regardless of backpressure; only completion can overflow.

Decomposition:
- Shared package uart_pkg:
  - BYTES_PER_WORD=4.
  - Default baud and clock constants (CLK_FREQ=50_000_000, BAUD=115200).
  - FSM state encoding: IDLE=1'b0, COLLECT=1'b1.
- One sub-module: sync_posedge_detect. It is a single-register rising-edge detector with synchronous active-high reset, used for recv_done. The existing edge capturers use asynchronous active-low reset and are not reused.

Test Plan (TIMEOUT_CYCLES=20 in the bench):
- Bytes 0x12,0x34,0x56,0x78 as 1-cycle recv_done pulses 10 cycles apart, ready=1.
  -> recv_4bytes_data=0x12345678; valid high 1 cycle after the 4th pulse, for 1 cycle.
  -> bytes_pending steps 1,2,3,0.
- recv_done held high for 5 cycles per byte, bytes 0xDE,0xAD,0xBE,0xEF.
  -> exactly one word, 0xDEADBEEF; no extra bytes.
- ready=0; send word 0x01020304, then word 0xA0B0C0D0.
  -> valid stays high with 0x01020304.
  -> overflow pulses once, 1 cycle after the 8th byte.
  -> raising ready gives 0x01020304 and valid drops.
- Bytes 0x11,0x22, then silence for 25 cycles.
  -> frame_timeout pulses once; bytes_pending returns to 0.
  -> next bytes 0x33,0x44,0x55,0x66 give 0x33445566.
- Valid held with ready=0; the 4th byte of the next word arrives in the cycle ready goes high.
  -> old word accepted, new word loaded on the same edge, valid stays high, no overflow.
- sys_rst asserted for 1 cycle after 3 bytes.
  -> bytes_pending=0 and all outputs 0.
  -> the following 4 bytes form a clean word with no timeout pulse.
